// File: rtl/oped_axis_pkg.sv
// Shared definitions for the OPED AXIS message generator.
//   - AXIS field widths and TUSER field positions
//   - FSM state encoding
//   - framing helpers: last-beat strobe and last-beat index from a byte length
package oped_axis_pkg;

    localparam int unsigned TDATA_W = 32;
    localparam int unsigned TSTRB_W = TDATA_W / 8;
    localparam int unsigned TUSER_W = 8;

    // TUSER field positions; only the opcode field fits the 8-bit TUSER bus.
    localparam int unsigned TUSER_OPC_LSB = 0;
    localparam int unsigned TUSER_OPC_MSB = 7;
    localparam int unsigned TUSER_LEN_LSB = 16;
    localparam int unsigned TUSER_LEN_MSB = 31;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StGap  = 2'd2
    } state_e;

    // Strobe for the final beat of a non-empty message.
    function automatic logic [TSTRB_W-1:0] last_strb(input logic [1:0] len_lo);
        logic [TSTRB_W-1:0] strb;
        unique case (len_lo)
            2'd0:    strb = 4'hF;
            2'd1:    strb = 4'h1;
            2'd2:    strb = 4'h3;
            default: strb = 4'h7;
        endcase
        return strb;
    endfunction

    // Index of the last beat: ceil(len/4) - 1, with an empty message still taking one beat.
    function automatic logic [15:0] last_beat_idx(input logic [15:0] len);
        logic [16:0] beats;
        beats = ({1'b0, len} + 17'd3) >> 2;
        return (beats == 17'd0) ? 16'd0 : 16'(beats - 17'd1);
    endfunction

endpackage

// File: rtl/oped_axis_pattern.sv
// Payload word generator.
//   ACLK, ARESET : clock, synchronous active-high reset
//   load         : restart the run (word <= seed, beat index <= 0)
//   advance      : a beat was accepted; step to the next word
//   new_msg      : the accepted beat ended a message; beat index restarts
//   mode         : 0 = seed + running word index, 1 = {msg_idx, beat_idx}
//   seed         : initial mode-0 word, sampled on load
//   msg_idx      : current message number for mode 1
//   data         : pattern word for the current beat
module oped_axis_pattern
    import oped_axis_pkg::*;
(
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic               load,
    input  logic               advance,
    input  logic               new_msg,
    input  logic               mode,
    input  logic [31:0]        seed,
    input  logic [15:0]        msg_idx,
    output logic [TDATA_W-1:0] data
);

    logic [31:0] word_q;
    logic [15:0] beat_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            word_q <= '0;
            beat_q <= '0;
        end else if (load) begin
            word_q <= seed;
            beat_q <= '0;
        end else if (advance) begin
            // The mode-0 word keeps counting across message boundaries.
            word_q <= word_q + 32'd1;
            beat_q <= new_msg ? 16'd0 : beat_q + 16'd1;
        end
    end

    always_comb begin
        data = mode ? {msg_idx, beat_q} : word_q;
    end

endmodule

// File: rtl/oped_axis_msg_gen.sv
// AXI4-Stream message transmitter feeding the OPED AXIS slave port.
//   ACLK, ARESET     : clock, synchronous active-high reset
//   start, abort     : run control (start latches cfg_*, abort ends after current message)
//   cfg_*            : opcode, byte length, message count (0 = endless), gap, mode, seed
//   M_AXIS_DAT_*     : AXIS master (TDATA/TVALID/TSTRB/TUSER/TLAST out, TREADY in)
//   busy, done       : run in progress, one-cycle end-of-run pulse
//   msgs_sent        : messages completed this run
//   beats_sent       : beats handshaken this run
module oped_axis_msg_gen
    import oped_axis_pkg::*;
#(
    parameter int unsigned GAP_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic               start,
    input  logic               abort,
    input  logic [7:0]         cfg_opcode,
    input  logic [15:0]        cfg_len_bytes,
    input  logic [CNT_W-1:0]   cfg_num_msgs,
    input  logic [GAP_W-1:0]   cfg_gap,
    input  logic               cfg_mode,
    input  logic [31:0]        cfg_seed,
    output logic [TDATA_W-1:0] M_AXIS_DAT_TDATA,
    output logic               M_AXIS_DAT_TVALID,
    output logic [TSTRB_W-1:0] M_AXIS_DAT_TSTRB,
    output logic [TUSER_W-1:0] M_AXIS_DAT_TUSER,
    output logic               M_AXIS_DAT_TLAST,
    input  logic               M_AXIS_DAT_TREADY,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   msgs_sent,
    output logic [31:0]        beats_sent
);

    state_e             state_q, state_d;
    logic [7:0]         opcode_q;
    logic [15:0]        len_q;
    logic [CNT_W-1:0]   num_q;
    logic [GAP_W-1:0]   gap_q;
    logic               mode_q;
    logic [15:0]        last_idx_q;
    logic [15:0]        beat_cnt_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic               abort_q;
    logic [CNT_W-1:0]   msgs_q;
    logic [31:0]        beats_q;
    logic               done_q;

    logic               sending;
    logic               hs;
    logic               is_last;
    logic               run_done;
    logic               abort_pend;
    logic               load;
    logic [TSTRB_W-1:0] strb;
    logic [TDATA_W-1:0] pat_data;

    assign sending    = (state_q == StSend);
    assign hs         = sending && M_AXIS_DAT_TREADY;
    assign is_last    = (beat_cnt_q == last_idx_q);
    assign run_done   = (num_q != '0) && ((msgs_q + CNT_W'(1)) == num_q);
    assign abort_pend = abort_q || abort;
    assign load       = (state_q == StIdle) && start;

    oped_axis_pattern u_pattern (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .load    (load),
        .advance (hs),
        .new_msg (hs && is_last),
        .mode    (mode_q),
        .seed    (cfg_seed),
        .msg_idx (16'(msgs_q)),
        .data    (pat_data)
    );

    // State register
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StSend;
            end
            StSend: begin
                if (hs && is_last) begin
                    if (run_done || abort_pend) state_d = StIdle;
                    else if (gap_q == '0)       state_d = StSend;
                    else                        state_d = StGap;
                end
            end
            StGap: begin
                if (abort_pend)             state_d = StIdle;
                else if (gap_cnt_q == '0)   state_d = StSend;
            end
            default: state_d = StIdle;
        endcase
    end

    // Run configuration, beat/gap counters and status counters
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            opcode_q   <= '0;
            len_q      <= '0;
            num_q      <= '0;
            gap_q      <= '0;
            mode_q     <= 1'b0;
            last_idx_q <= '0;
            beat_cnt_q <= '0;
            gap_cnt_q  <= '0;
            abort_q    <= 1'b0;
            msgs_q     <= '0;
            beats_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state_q != StIdle) && (state_d == StIdle);
            if (state_q == StIdle) begin
                // abort is ignored here, including when it coincides with start.
                if (start) begin
                    opcode_q   <= cfg_opcode;
                    len_q      <= cfg_len_bytes;
                    num_q      <= cfg_num_msgs;
                    gap_q      <= cfg_gap;
                    mode_q     <= cfg_mode;
                    last_idx_q <= last_beat_idx(cfg_len_bytes);
                    beat_cnt_q <= '0;
                    msgs_q     <= '0;
                    beats_q    <= '0;
                    abort_q    <= 1'b0;
                end
            end else begin
                if (state_d == StIdle) abort_q <= 1'b0;
                else if (abort)        abort_q <= 1'b1;
                if (hs) begin
                    beats_q <= beats_q + 32'd1;
                    if (is_last) begin
                        msgs_q     <= msgs_q + CNT_W'(1);
                        beat_cnt_q <= '0;
                    end else begin
                        beat_cnt_q <= beat_cnt_q + 16'd1;
                    end
                end
                // Loaded with gap-1 so the GAP state lasts exactly gap cycles.
                if (sending && state_d == StGap) gap_cnt_q <= gap_q - GAP_W'(1);
                else if (state_q == StGap)       gap_cnt_q <= gap_cnt_q - GAP_W'(1);
            end
        end
    end

    always_comb begin
        strb = '0;
        if (!is_last)           strb = '1;
        else if (len_q != '0)   strb = last_strb(len_q[1:0]);
    end

    // Outputs; payload is forced to zero whenever no beat is offered.
    always_comb begin
        M_AXIS_DAT_TVALID = sending;
        M_AXIS_DAT_TDATA  = sending ? pat_data : '0;
        M_AXIS_DAT_TSTRB  = sending ? strb : '0;
        M_AXIS_DAT_TUSER  = '0;
        M_AXIS_DAT_TUSER[TUSER_OPC_MSB:TUSER_OPC_LSB] = sending ? opcode_q : 8'h00;
        M_AXIS_DAT_TLAST  = sending && is_last;
        busy              = (state_q != StIdle);
        done              = done_q;
        msgs_sent         = msgs_q;
        beats_sent        = beats_q;
    end

endmodule
